// File: rtl/axi_raddr.sv
// AXI3 read-address channel generator for the DMA engine: splits a word-count
// request into INCR bursts of up to 16 beats, optionally cut at 4KB boundaries.
module axi_raddr (
  input  logic        aclk,
  input  logic        areset,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic        dma_axi_start,
  output logic        dma_axi_raddr_free,
  input  logic [31:0] dma_cfg_saddr,
  input  logic [13:0] dma_cfg_number,
  input  logic        dma_cfg_sexceed_4k
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    REQ
  } state_t;

  state_t      state;
  logic [31:0] cur_addr;
  logic [13:0] remaining;
  logic        exceed_4k;
  logic [4:0]  beats;
  logic [4:0]  beats_next;
  logic [10:0] words_to_4k;

  // Words left before the next 4KB page, counted from the word containing cur_addr (1..1024).
  // NOTE: every combinational output gets a default at the top, so no path can infer a latch.
  always_comb begin
    beats_next  = (remaining > 14'd16) ? 5'd16 : remaining[4:0];
    words_to_4k = 11'd1024 - {1'b0, cur_addr[11:2]};
    if (exceed_4k && ({6'd0, beats_next} > words_to_4k)) begin
      beats_next = words_to_4k[4:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state              <= IDLE;
      araddr             <= '0;
      arlen              <= '0;
      arvalid            <= 1'b0;
      dma_axi_raddr_free <= 1'b1;
      cur_addr           <= '0;
      remaining          <= '0;
      exceed_4k          <= 1'b0;
      beats              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_axi_start && (dma_cfg_number != 14'd0)) begin
            cur_addr           <= dma_cfg_saddr;
            remaining          <= dma_cfg_number;
            exceed_4k          <= dma_cfg_sexceed_4k;
            dma_axi_raddr_free <= 1'b0;
            state              <= CALC;
          end
        end

        CALC: begin
          beats   <= beats_next;
          araddr  <= cur_addr;
          arlen   <= beats_next[3:0] - 4'd1;
          arvalid <= 1'b1;
          state   <= REQ;
        end

        REQ: begin
          // arvalid is always high here, so arready alone marks the handshake.
          if (arready) begin
            arvalid   <= 1'b0;
            remaining <= remaining - {9'd0, beats};
            cur_addr  <= {cur_addr[31:2], 2'b00} + {25'd0, beats, 2'b00};
            if (remaining == {9'd0, beats}) begin
              dma_axi_raddr_free <= 1'b1;
              state              <= IDLE;
            end else begin
              state <= CALC;
            end
          end
        end

        default: begin
          arvalid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_raddr.sv
// Directed self-checking bench for axi_raddr: burst splitting, 4KB cuts,
// back-pressure, ignored starts and reset mid-request.
module tb_axi_raddr;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic        dma_axi_start;
  logic        dma_axi_raddr_free;
  logic [31:0] dma_cfg_saddr;
  logic [13:0] dma_cfg_number;
  logic        dma_cfg_sexceed_4k;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [4];
  logic [3:0]  exp_len  [4];

  axi_raddr dut (
    .aclk               (aclk),
    .areset             (areset),
    .araddr             (araddr),
    .arlen              (arlen),
    .arvalid            (arvalid),
    .arready            (arready),
    .dma_axi_start      (dma_axi_start),
    .dma_axi_raddr_free (dma_axi_raddr_free),
    .dma_cfg_saddr      (dma_cfg_saddr),
    .dma_cfg_number     (dma_cfg_number),
    .dma_cfg_sexceed_4k (dma_cfg_sexceed_4k)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives a one-cycle start pulse; returns at the negedge after the sampling edge.
  task automatic pulse_start(input logic [31:0] saddr, input logic [13:0] num, input logic exc);
    @(negedge aclk);
    dma_cfg_saddr      = saddr;
    dma_cfg_number     = num;
    dma_cfg_sexceed_4k = exc;
    dma_axi_start      = 1'b1;
    @(negedge aclk);
    dma_axi_start      = 1'b0;
  endtask

  // Waits (bounded) at negedges for arvalid, then checks the presented burst.
  task automatic wait_burst(input string tag, input logic [31:0] ea, input logic [3:0] el);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    check({tag, "_seen"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      check({tag, "_addr"}, araddr, ea);
      check({tag, "_len"},  {28'd0, arlen}, {28'd0, el});
    end
  endtask

  // Consumes nb expected bursts; on the first one arready is held low for stall
  // cycles while a competing start pulse with different config is issued.
  task automatic run_bursts(input string tag, input int nb, input int stall);
    for (int b = 0; b < nb; b++) begin
      wait_burst($sformatf("%s_b%0d", tag, b), exp_addr[b], exp_len[b]);
      if (b == 0 && stall > 0) begin
        for (int i = 0; i < stall; i++) begin
          if (i == 0) begin
            dma_cfg_saddr      = 32'hDEAD_0000;
            dma_cfg_number     = 14'd3;
            dma_cfg_sexceed_4k = 1'b1;
            dma_axi_start      = 1'b1;
          end else begin
            dma_axi_start = 1'b0;
          end
          @(negedge aclk);
          check($sformatf("%s_stall%0d_valid", tag, i), {31'd0, arvalid}, 32'd1);
          check($sformatf("%s_stall%0d_addr", tag, i), araddr, exp_addr[0]);
          check($sformatf("%s_stall%0d_len", tag, i), {28'd0, arlen}, {28'd0, exp_len[0]});
        end
        arready = 1'b1;
      end
      @(negedge aclk);
    end
    check({tag, "_done_valid"}, {31'd0, arvalid}, 32'd0);
    check({tag, "_done_free"}, {31'd0, dma_axi_raddr_free}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check($sformatf("%s_quiet%0d", tag, i), {31'd0, arvalid}, 32'd0);
    end
  endtask

  initial begin
    areset             = 1'b1;
    arready            = 1'b1;
    dma_axi_start      = 1'b0;
    dma_cfg_saddr      = '0;
    dma_cfg_number     = '0;
    dma_cfg_sexceed_4k = 1'b0;

    // Reset holds the block idle even while start pulses arrive.
    pulse_start(32'h0, 14'd50, 1'b0);
    pulse_start(32'h100, 14'd8, 1'b0);
    check("rst_valid", {31'd0, arvalid}, 32'd0);
    check("rst_addr",  araddr, 32'd0);
    check("rst_len",   {28'd0, arlen}, 32'd0);
    check("rst_free",  {31'd0, dma_axi_raddr_free}, 32'd1);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // 50 words from 0, no 4KB handling: 16+16+16+2.
    exp_addr = '{32'h000, 32'h040, 32'h080, 32'h0C0};
    exp_len  = '{4'd15, 4'd15, 4'd15, 4'd1};
    pulse_start(32'h0, 14'd50, 1'b0);
    check("lat_free", {31'd0, dma_axi_raddr_free}, 32'd0);
    check("lat_calc", {31'd0, arvalid}, 32'd0);
    @(negedge aclk);
    check("lat_req", {31'd0, arvalid}, 32'd1);
    run_bursts("seq", 4, 0);

    // Unaligned start three words below 0x1000 with splitting enabled.
    exp_addr = '{32'hFF5, 32'h1000, 32'h1040, 32'h1080};
    exp_len  = '{4'd2, 4'd15, 4'd15, 4'd14};
    pulse_start(32'hFF5, 14'd50, 1'b1);
    run_bursts("b4k", 4, 0);

    // Back-pressure on burst 1 plus an ignored mid-transfer start.
    exp_addr = '{32'h000, 32'h040, 32'h080, 32'h0C0};
    exp_len  = '{4'd15, 4'd15, 4'd15, 4'd1};
    arready  = 1'b0;
    pulse_start(32'h0, 14'd50, 1'b0);
    run_bursts("stl", 4, 5);

    // number==0 is ignored.
    pulse_start(32'h400, 14'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("zero%0d_valid", i), {31'd0, arvalid}, 32'd0);
      check($sformatf("zero%0d_free", i), {31'd0, dma_axi_raddr_free}, 32'd1);
      @(negedge aclk);
    end

    // Reset while a request is pending aborts it immediately.
    arready = 1'b0;
    pulse_start(32'h100, 14'd20, 1'b0);
    wait_burst("rreq", 32'h100, 4'd15);
    areset = 1'b1;
    @(negedge aclk);
    check("rreq_valid", {31'd0, arvalid}, 32'd0);
    check("rreq_free",  {31'd0, dma_axi_raddr_free}, 32'd1);
    check("rreq_addr",  araddr, 32'd0);
    areset  = 1'b0;
    arready = 1'b1;

    // A fresh transfer after the abort: 16 + 4 words.
    exp_addr = '{32'h200, 32'h240, 32'h0, 32'h0};
    exp_len  = '{4'd15, 4'd3, 4'd0, 4'd0};
    pulse_start(32'h200, 14'd20, 1'b0);
    run_bursts("post", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
